// File: rtl/udp_session_pkg.sv
// Shared types for the UDP session sequencer: ACK codes, FSM states and the
// 15-bit sequence-number arithmetic (0 is reserved, so 0x7FFF wraps to 1).
package udp_session_pkg;

    localparam int SEQ_W = 15;
    localparam logic [SEQ_W-1:0] SEQ_MAX = {SEQ_W{1'b1}};

    typedef enum logic [1:0] {
        ACK_START = 2'd0,
        ACK_SEQ   = 2'd1,
        NACK      = 2'd2,
        ACK_STOP  = 2'd3
    } ack_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    function automatic logic [SEQ_W-1:0] nextSeq(input logic [SEQ_W-1:0] s);
        return (s == SEQ_MAX) ? SEQ_W'(1) : s + SEQ_W'(1);
    endfunction

    // Inverse of nextSeq, used to recognise a repeat of the last accepted packet.
    function automatic logic [SEQ_W-1:0] prevSeq(input logic [SEQ_W-1:0] s);
        return (s == SEQ_W'(1)) ? SEQ_MAX : s - SEQ_W'(1);
    endfunction

endpackage

// File: rtl/udp_session_ctrl_if.sv
// ACK/NACK request channel from the session sequencer to the TX path.
interface udp_session_ctrl_if;
    import udp_session_pkg::*;

    logic             ackvalid;
    logic             ackready;
    logic [1:0]       acktype;
    logic [SEQ_W-1:0] ackseq;

    modport master (output ackvalid, output acktype, output ackseq, input ackready);
    modport slave  (input ackvalid, input acktype, input ackseq, output ackready);

endinterface

// File: rtl/udp_session_ctrl_ack_slot.sv
// One-entry registered holding slot for ACK/NACK requests. A push into a full,
// unaccepted slot is dropped and flagged; a push on the accept cycle replaces it.
module ack_slot
    import udp_session_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  ack_type_e        pushType,
    input  logic [SEQ_W-1:0] pushSeq,
    output logic             overflow,
    udp_session_ctrl_if.master ack
);

    logic accepted;

    assign accepted = ack.ackvalid && ack.ackready;
    assign overflow = push && ack.ackvalid && !accepted;

    always_ff @(posedge clock) begin
        if (reset) begin
            ack.ackvalid <= 1'b0;
            ack.acktype  <= 2'd0;
            ack.ackseq   <= '0;
        end else if (push && !overflow) begin
            ack.ackvalid <= 1'b1;
            ack.acktype  <= pushType;
            ack.ackseq   <= pushSeq;
        end else if (accepted) begin
            ack.ackvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/udp_session_ctrl.sv
// Session sequencer: tracks IDLE/ACTIVE, the expected sequence number, the idle
// timeout with bounded retries, and saturating statistics; ACKs go via ack_slot.
module udp_session_ctrl
    import udp_session_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             startvalid,
    input  logic             stopvalid,
    input  logic             sequencevalid,
    input  logic [SEQ_W-1:0] sequenceno,
    input  logic             checksummatch,
    udp_session_ctrl_if.master ack,
    output logic             seqaccept,
    output logic [SEQ_W-1:0] seqacceptno,
    output logic             sessionactive,
    output logic             sessionabort,
    output logic [CNT_W-1:0] rxcount,
    output logic [CNT_W-1:0] errcount
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    state_e           state, stateNext;
    logic [SEQ_W-1:0] expectedSeq, expectedNext;
    logic [TMR_W-1:0] timer, timerNext;
    logic [RTY_W-1:0] retry, retryNext;

    logic             anyStrobe;
    logic             startSession;
    logic             push;
    ack_type_e        pushType;
    logic [SEQ_W-1:0] pushSeq;
    logic             overflow;
    logic             acceptNext;
    logic [SEQ_W-1:0] acceptNoNext;
    logic             abortNext;
    logic             badCsum;
    logic             gapErr;
    logic [1:0]       errInc;
    logic [CNT_W:0]   errSum;

    assign anyStrobe     = startvalid || stopvalid || sequencevalid;
    assign sessionactive = (state == ACTIVE);

    always_comb begin
        stateNext    = state;
        expectedNext = expectedSeq;
        timerNext    = timer;
        retryNext    = retry;
        startSession = 1'b0;
        push         = 1'b0;
        pushType     = ACK_SEQ;
        pushSeq      = '0;
        acceptNext   = 1'b0;
        acceptNoNext = '0;
        abortNext    = 1'b0;
        badCsum      = 1'b0;
        gapErr       = 1'b0;

        if (state == IDLE) begin
            if (startvalid) begin
                if (checksummatch) startSession = 1'b1;
                else               badCsum      = 1'b1;
            end
        end else if (anyStrobe && !checksummatch) begin
            // A bad strobe still suppresses the timeout; the timer holds at its last count.
            badCsum = 1'b1;
            if (timer != TMR_LAST) timerNext = timer + TMR_W'(1);
        end else if (startvalid) begin
            startSession = 1'b1;
        end else if (stopvalid) begin
            push      = 1'b1;
            pushType  = ACK_STOP;
            pushSeq   = expectedSeq - SEQ_W'(1);
            stateNext = IDLE;
            timerNext = '0;
            retryNext = '0;
        end else if (sequencevalid) begin
            timerNext = '0;
            retryNext = '0;
            push      = 1'b1;
            if (sequenceno == expectedSeq) begin
                acceptNext   = 1'b1;
                acceptNoNext = sequenceno;
                expectedNext = nextSeq(expectedSeq);
                pushSeq      = sequenceno;
            end else if (sequenceno == prevSeq(expectedSeq)) begin
                pushSeq = sequenceno;
            end else begin
                pushType = NACK;
                pushSeq  = expectedSeq;
                gapErr   = 1'b1;
            end
        end else if (timer == TMR_LAST) begin
            timerNext = '0;
            if (retry == RTY_MAX) begin
                abortNext = 1'b1;
                stateNext = IDLE;
                retryNext = '0;
            end else begin
                push      = 1'b1;
                pushType  = NACK;
                pushSeq   = expectedSeq;
                retryNext = retry + RTY_W'(1);
            end
        end else begin
            timerNext = timer + TMR_W'(1);
        end

        if (startSession) begin
            stateNext    = ACTIVE;
            expectedNext = SEQ_W'(1);
            timerNext    = '0;
            retryNext    = '0;
            push         = 1'b1;
            pushType     = ACK_START;
            pushSeq      = '0;
        end
    end

    // A gap NACK that also overflows the slot counts as two errors.
    assign errInc = {1'b0, badCsum} + {1'b0, gapErr} + {1'b0, overflow};
    assign errSum = {1'b0, errcount} + {{(CNT_W-1){1'b0}}, errInc};

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            expectedSeq <= SEQ_W'(1);
            timer       <= '0;
            retry       <= '0;
            seqaccept   <= 1'b0;
            seqacceptno <= '0;
            sessionabort <= 1'b0;
            rxcount     <= '0;
            errcount    <= '0;
        end else begin
            state        <= stateNext;
            expectedSeq  <= expectedNext;
            timer        <= timerNext;
            retry        <= retryNext;
            seqaccept    <= acceptNext;
            seqacceptno  <= acceptNoNext;
            sessionabort <= abortNext;
            if (acceptNext && (rxcount != {CNT_W{1'b1}})) rxcount <= rxcount + CNT_W'(1);
            errcount <= errSum[CNT_W] ? {CNT_W{1'b1}} : errSum[CNT_W-1:0];
        end
    end

    ack_slot u_ack_slot (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pushType (pushType),
        .pushSeq  (pushSeq),
        .overflow (overflow),
        .ack      (ack)
    );

endmodule

// File: tb/tb_udp_session_ctrl.sv
// Directed bench for udp_session_ctrl: a cycle model built from the session
// rules is compared against the DUT every cycle, plus hand-computed spot values.
module tb_udp_session_ctrl;

    localparam int TMO   = 8;
    localparam int MAXR  = 2;
    localparam int CNTMX = 65535;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        startvalid = 1'b0;
    logic        stopvalid = 1'b0;
    logic        sequencevalid = 1'b0;
    logic [14:0] sequenceno = '0;
    logic        checksummatch = 1'b0;
    logic        seqaccept;
    logic [14:0] seqacceptno;
    logic        sessionactive;
    logic        sessionabort;
    logic [15:0] rxcount;
    logic [15:0] errcount;

    udp_session_ctrl_if ackIf ();

    udp_session_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR), .CNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .startvalid    (startvalid),
        .stopvalid     (stopvalid),
        .sequencevalid (sequencevalid),
        .sequenceno    (sequenceno),
        .checksummatch (checksummatch),
        .ack           (ackIf.master),
        .seqaccept     (seqaccept),
        .seqacceptno   (seqacceptno),
        .sessionactive (sessionactive),
        .sessionabort  (sessionabort),
        .rxcount       (rxcount),
        .errcount      (errcount)
    );

    always #5 clock = ~clock;

    int checkCount = 0;
    int passCount  = 0;
    bit cmpEn      = 1'b0;
    int xferCount  = 0;

    // Session model state, in plain integers.
    bit mActive, mFull, mAcc, mAbort;
    int mExp, mIdle, mRetry, mType, mSeq, mAccNo, mRx, mErr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    endtask

    function automatic int modelNext(input int s);
        return (s % 32767) + 1;
    endfunction

    function automatic int modelPrev(input int s);
        return ((s + 32765) % 32767) + 1;
    endfunction

    always @(posedge clock) begin : model
        bit xfer, want, anyS;
        int err, wType, wSeq;
        if (reset) begin
            mActive = 0; mFull = 0; mAcc = 0; mAbort = 0;
            mExp = 1; mIdle = 0; mRetry = 0; mType = 0; mSeq = 0;
            mAccNo = 0; mRx = 0; mErr = 0;
        end else begin
            xfer = mFull && ackIf.ackready;
            anyS = startvalid || stopvalid || sequencevalid;
            want = 0; err = 0; wType = 0; wSeq = 0;
            mAcc = 0; mAbort = 0;
            if (!mActive) begin
                if (startvalid) begin
                    if (checksummatch) begin
                        mActive = 1; mExp = 1; mIdle = 0; mRetry = 0; want = 1; wType = 0; wSeq = 0;
                    end else err++;
                end
            end else if (anyS && !checksummatch) begin
                err++;
                if (mIdle < TMO - 1) mIdle++;
            end else if (anyS) begin
                mIdle = 0; mRetry = 0;
                if (startvalid) begin
                    mExp = 1; want = 1; wType = 0; wSeq = 0;
                end else if (stopvalid) begin
                    want = 1; wType = 3; wSeq = (mExp - 1) & 32'h7FFF; mActive = 0;
                end else if (sequenceno == mExp) begin
                    mAcc = 1; mAccNo = mExp; mRx = (mRx < CNTMX) ? mRx + 1 : CNTMX;
                    want = 1; wType = 1; wSeq = mExp; mExp = modelNext(mExp);
                end else if (sequenceno == modelPrev(mExp)) begin
                    want = 1; wType = 1; wSeq = sequenceno;
                end else begin
                    want = 1; wType = 2; wSeq = mExp; err++;
                end
            end else if (mIdle == TMO - 1) begin
                mIdle = 0;
                if (mRetry == MAXR) begin
                    mAbort = 1; mActive = 0; mRetry = 0;
                end else begin
                    want = 1; wType = 2; wSeq = mExp; mRetry++;
                end
            end else mIdle++;

            if (want) begin
                if (!mFull || xfer) begin mFull = 1; mType = wType; mSeq = wSeq; end
                else err++;
            end else if (xfer) mFull = 0;
            mErr = (mErr + err > CNTMX) ? CNTMX : mErr + err;
        end
    end

    always @(posedge clock) if (ackIf.ackvalid && ackIf.ackready) xferCount++;

    always @(negedge clock) begin
        if (cmpEn) begin
            checkOutput("ackvalid", ackIf.ackvalid, mFull);
            if (mFull) begin
                checkOutput("acktype", ackIf.acktype, mType);
                checkOutput("ackseq", ackIf.ackseq, mSeq);
            end
            checkOutput("seqaccept", seqaccept, mAcc);
            if (mAcc) checkOutput("seqacceptno", seqacceptno, mAccNo);
            checkOutput("sessionactive", sessionactive, mActive);
            checkOutput("sessionabort", sessionabort, mAbort);
            checkOutput("rxcount", rxcount, mRx);
            checkOutput("errcount", errcount, mErr);
        end
    end

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        cmpEn = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drive one strobe for a single sampling edge; returns on the following negedge.
    task automatic applyStimulus(input bit st, input bit sp, input bit sq, input int no, input bit ok);
        startvalid    = st;
        stopvalid     = sp;
        sequencevalid = sq;
        sequenceno    = 15'(no);
        checksummatch = ok;
        @(negedge clock);
        startvalid    = 1'b0;
        stopvalid     = 1'b0;
        sequencevalid = 1'b0;
        checksummatch = 1'b0;
    endtask

    int nackCount, firstNack, lastNack, abortAt;

    initial begin
        ackIf.ackready = 1'b1;
        resetDut();
        checkOutput("reset_ackvalid", ackIf.ackvalid, 0);
        checkOutput("reset_active", sessionactive, 0);
        checkOutput("reset_rxcount", rxcount, 0);

        $display("[TB] test 1: start then in-order 1..3");
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t1_start_type", ackIf.acktype, 0);
        checkOutput("t1_start_seq", ackIf.ackseq, 0);
        checkOutput("t1_active", sessionactive, 1);
        for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 1, i, 1);
        checkOutput("t1_accept", seqaccept, 1);
        checkOutput("t1_ackseq", ackIf.ackseq, 3);
        checkOutput("t1_rxcount", rxcount, 3);

        $display("[TB] test 2: gap, duplicate, stop+seq priority");
        applyStimulus(0, 0, 1, 4, 1);
        applyStimulus(0, 0, 1, 7, 1);
        checkOutput("t2_nack_type", ackIf.acktype, 2);
        checkOutput("t2_nack_seq", ackIf.ackseq, 5);
        checkOutput("t2_errcount", errcount, 1);
        applyStimulus(0, 0, 1, 4, 1);
        checkOutput("t2_dup_type", ackIf.acktype, 1);
        checkOutput("t2_dup_seq", ackIf.ackseq, 4);
        checkOutput("t2_dup_noaccept", seqaccept, 0);
        checkOutput("t2_dup_rxcount", rxcount, 4);
        applyStimulus(0, 1, 1, 5, 1);
        checkOutput("t2_stop_type", ackIf.acktype, 3);
        checkOutput("t2_stop_seq", ackIf.ackseq, 4);
        checkOutput("t2_stop_idle", sessionactive, 0);
        @(negedge clock);

        $display("[TB] test 3: sequence wrap 0x7FFF -> 1");
        resetDut();
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 1; i <= 32767; i++) applyStimulus(0, 0, 1, i, 1);
        checkOutput("t3_acceptno_max", seqacceptno, 32767);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("t3_wrap_accept", seqaccept, 1);
        checkOutput("t3_wrap_acceptno", seqacceptno, 1);
        checkOutput("t3_rxcount", rxcount, 32768);
        applyStimulus(0, 1, 0, 0, 1);

        $display("[TB] test 4: backpressure and overflow");
        resetDut();
        ackIf.ackready = 1'b0;
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("t4_overflow_err", errcount, 1);
        checkOutput("t4_held_type", ackIf.acktype, 0);
        checkOutput("t4_rxcount", rxcount, 1);
        for (int i = 0; i < 10; i++) @(negedge clock);
        checkOutput("t4_still_valid", ackIf.ackvalid, 1);
        checkOutput("t4_still_type", ackIf.acktype, 0);
        checkOutput("t4_timeout_overflow", errcount, 2);
        xferCount = 0;
        ackIf.ackready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("t4_one_transfer", xferCount, 1);
        checkOutput("t4_drained", ackIf.ackvalid, 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("t4_stop_seq", ackIf.ackseq, 1);

        $display("[TB] test 5: timeout retries and abort");
        resetDut();
        applyStimulus(1, 0, 0, 0, 1);
        nackCount = 0; firstNack = 0; lastNack = 0; abortAt = 0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clock);
            if (ackIf.ackvalid && ackIf.acktype == 2'd2) begin
                nackCount++;
                if (nackCount == 1) firstNack = k;
                else lastNack = k;
            end
            if (sessionabort) abortAt = k;
        end
        checkOutput("t5_nack_count", nackCount, 2);
        checkOutput("t5_first_nack", firstNack, 8);
        checkOutput("t5_second_nack", lastNack, 16);
        checkOutput("t5_abort_cycle", abortAt, 24);
        checkOutput("t5_idle", sessionactive, 0);

        $display("[TB] test 6: bad checksum and mid-session reset");
        resetDut();
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_bad_idle", sessionactive, 0);
        checkOutput("t6_bad_noack", ackIf.ackvalid, 0);
        checkOutput("t6_bad_err", errcount, 1);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("t6_idle_ignore", errcount, 1);
        ackIf.ackready = 1'b0;
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t6_rst_ackvalid", ackIf.ackvalid, 0);
        checkOutput("t6_rst_active", sessionactive, 0);
        checkOutput("t6_rst_rxcount", rxcount, 0);
        checkOutput("t6_rst_errcount", errcount, 0);
        reset = 1'b0;
        ackIf.ackready = 1'b1;
        @(negedge clock);
        @(negedge clock);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
